// File: rtl/tile_dispatcher.sv
// Tile dispatcher: decodes a command stream into solver-lane limb writes and starts,
// and returns per-lane iteration results to a round-robin arbitrated output stream.
module tile_dispatcher #(
  parameter int NUM_LANES       = 4,
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 27
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [31:0]                  in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_end_of_stream,
  output logic [31:0]                  out_addr,
  output logic [15:0]                  out_data,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_LANES-1:0]         s_wr_real_en,
  output logic [NUM_LANES-1:0]         s_wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0]   s_wr_index,
  output logic [LIMB_SIZE_BITS-1:0]    s_limb_data,
  output logic                         s_wr_num_limbs_en,
  output logic [LIMB_INDEX_BITS-1:0]   s_num_limbs,
  output logic                         s_wr_iter_lim_en,
  output logic [15:0]                  s_iter_lim,
  output logic [NUM_LANES-1:0]         s_start,
  input  logic [NUM_LANES-1:0]         s_done,
  input  logic [16*NUM_LANES-1:0]      s_iterations
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(NUM_LANES - 1);
  localparam logic [LANE_W:0]   LANE_COUNT = (LANE_W + 1)'(NUM_LANES);

  localparam logic [2:0] CMD_BASE   = 3'd0;
  localparam logic [2:0] CMD_CONFIG = 3'd1;
  localparam logic [2:0] CMD_REAL   = 3'd2;
  localparam logic [2:0] CMD_IMAG   = 3'd3;
  localparam logic [2:0] CMD_START  = 3'd4;

  typedef enum logic [1:0] {
    LANE_IDLE = 2'd0,
    LANE_BUSY = 2'd1,
    LANE_DONE = 2'd2
  } lane_state_t;

  lane_state_t                lane_state_r [NUM_LANES];
  lane_state_t                lane_state_s [NUM_LANES];
  logic [31:0]                lane_tag_r   [NUM_LANES];
  logic [31:0]                lane_tag_s   [NUM_LANES];
  logic [15:0]                lane_iter_r  [NUM_LANES];
  logic [15:0]                lane_iter_s  [NUM_LANES];

  logic [31:0]                base_addr_r, base_addr_s;
  logic [LIMB_INDEX_BITS-1:0] real_idx_r, real_idx_s;
  logic [LIMB_INDEX_BITS-1:0] imag_idx_r, imag_idx_s;
  logic [LANE_W-1:0]          load_ptr_r, load_ptr_s;
  logic [LANE_W-1:0]          last_grant_r, last_grant_s;
  logic [LANE_W-1:0]          out_lane_r, out_lane_s;
  logic                       eos_pending_r, eos_pending_s;

  logic                       out_valid_r, out_valid_s;
  logic                       out_last_r, out_last_s;
  logic [31:0]                out_addr_r, out_addr_s;
  logic [15:0]                out_data_r, out_data_s;

  logic [NUM_LANES-1:0]       wr_real_en_r, wr_real_en_s;
  logic [NUM_LANES-1:0]       wr_imag_en_r, wr_imag_en_s;
  logic [NUM_LANES-1:0]       start_r, start_s;
  logic [LIMB_INDEX_BITS-1:0] wr_index_r, wr_index_s;
  logic [LIMB_INDEX_BITS-1:0] num_limbs_r, num_limbs_s;
  logic [LIMB_SIZE_BITS-1:0]  limb_data_r, limb_data_s;
  logic                       wr_num_limbs_en_r, wr_num_limbs_en_s;
  logic                       wr_iter_lim_en_r, wr_iter_lim_en_s;
  logic [15:0]                iter_lim_r, iter_lim_s;

  logic [2:0]                 cmd_type_s;
  logic [28:0]                payload_s;
  logic                       all_idle_s, load_idle_s, ready_s, accept_s;
  logic                       out_hs_s, grant_found_s, grant_hit_s;
  logic                       others_active_s, eos_clear_s;
  logic [LANE_W:0]            cand_sum_s;
  logic [LANE_W-1:0]          cand_s, grant_lane_s;

  // Command decode and input flow control from registered lane state.
  always_comb begin
    cmd_type_s  = in_data[31:29];
    payload_s   = in_data[28:0];
    all_idle_s  = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      all_idle_s = all_idle_s & (lane_state_r[i] == LANE_IDLE);
    end
    load_idle_s = (lane_state_r[load_ptr_r] == LANE_IDLE);
    case (cmd_type_s)
      CMD_BASE:   ready_s = 1'b1;
      CMD_CONFIG: ready_s = all_idle_s;
      CMD_REAL,
      CMD_IMAG,
      CMD_START:  ready_s = load_idle_s;
      default:    ready_s = 1'b1;
    endcase
    accept_s = in_valid & ready_s & ~reset;
  end

  assign in_ready = ready_s & ~reset;

  // Next-state computation for lanes, counters, solver strobes and output arbiter.
  always_comb begin
    lane_state_s      = lane_state_r;
    lane_tag_s        = lane_tag_r;
    lane_iter_s       = lane_iter_r;
    base_addr_s       = base_addr_r;
    real_idx_s        = real_idx_r;
    imag_idx_s        = imag_idx_r;
    load_ptr_s        = load_ptr_r;
    last_grant_s      = last_grant_r;
    out_lane_s        = out_lane_r;
    out_valid_s       = out_valid_r;
    out_addr_s        = out_addr_r;
    out_data_s        = out_data_r;
    wr_real_en_s      = '0;
    wr_imag_en_s      = '0;
    start_s           = '0;
    wr_num_limbs_en_s = 1'b0;
    wr_iter_lim_en_s  = 1'b0;
    wr_index_s        = wr_index_r;
    num_limbs_s       = num_limbs_r;
    limb_data_s       = limb_data_r;
    iter_lim_s        = iter_lim_r;
    grant_found_s     = 1'b0;
    grant_hit_s       = 1'b0;
    grant_lane_s      = '0;
    cand_sum_s        = '0;
    cand_s            = '0;
    others_active_s   = 1'b0;

    if (accept_s) begin
      case (cmd_type_s)
        CMD_BASE: base_addr_s = {3'b000, payload_s};
        CMD_CONFIG: begin
          iter_lim_s        = payload_s[15:0];
          num_limbs_s       = payload_s[16 +: LIMB_INDEX_BITS];
          wr_iter_lim_en_s  = 1'b1;
          wr_num_limbs_en_s = 1'b1;
        end
        CMD_REAL: begin
          wr_real_en_s[load_ptr_r] = 1'b1;
          wr_index_s               = real_idx_r;
          limb_data_s              = payload_s[LIMB_SIZE_BITS-1:0];
          real_idx_s               = real_idx_r + {{(LIMB_INDEX_BITS-1){1'b0}}, 1'b1};
        end
        CMD_IMAG: begin
          wr_imag_en_s[load_ptr_r] = 1'b1;
          wr_index_s               = imag_idx_r;
          limb_data_s              = payload_s[LIMB_SIZE_BITS-1:0];
          imag_idx_s               = imag_idx_r + {{(LIMB_INDEX_BITS-1){1'b0}}, 1'b1};
        end
        CMD_START: begin
          start_s[load_ptr_r]      = 1'b1;
          lane_state_s[load_ptr_r] = LANE_BUSY;
          lane_tag_s[load_ptr_r]   = base_addr_r;
          base_addr_s              = base_addr_r + 32'd1;
          real_idx_s               = '0;
          imag_idx_s               = '0;
          load_ptr_s               = (load_ptr_r == LAST_LANE) ? '0 : load_ptr_r + {{(LANE_W-1){1'b0}}, 1'b1};
        end
        default: base_addr_s = base_addr_r;
      endcase
    end else begin
      base_addr_s = base_addr_r;
    end

    // Completion pulses only count for lanes still solving.
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_state_r[i] == LANE_BUSY && s_done[i]) begin
        lane_state_s[i] = LANE_DONE;
        lane_iter_s[i]  = s_iterations[16*i +: 16];
      end else begin
        lane_iter_s[i]  = lane_iter_r[i];
      end
    end

    out_hs_s = out_valid_r & out_ready;
    if (out_hs_s) begin
      lane_state_s[out_lane_r] = LANE_IDLE;
      out_valid_s              = 1'b0;
    end else begin
      out_valid_s              = out_valid_r;
    end

    // Search starts one past the last grant; the lane on display is never re-picked.
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand_sum_s    = {1'b0, last_grant_r} + (LANE_W + 1)'(k);
      cand_sum_s    = (cand_sum_s >= LANE_COUNT) ? cand_sum_s - LANE_COUNT : cand_sum_s;
      cand_s        = cand_sum_s[LANE_W-1:0];
      grant_hit_s   = (lane_state_r[cand_s] == LANE_DONE) && !(out_valid_r && cand_s == out_lane_r);
      grant_lane_s  = (grant_hit_s && !grant_found_s) ? cand_s : grant_lane_s;
      grant_found_s = grant_found_s | grant_hit_s;
    end

    if ((!out_valid_r || out_hs_s) && grant_found_s) begin
      out_valid_s  = 1'b1;
      out_lane_s   = grant_lane_s;
      out_addr_s   = lane_tag_r[grant_lane_s];
      out_data_s   = lane_iter_r[grant_lane_s];
      last_grant_s = grant_lane_s;
    end else begin
      out_lane_s   = out_lane_r;
    end

    eos_clear_s   = (out_hs_s & out_last_r) |
                    (all_idle_s & ~out_valid_r & ~(accept_s & (cmd_type_s == CMD_START)));
    eos_pending_s = in_end_of_stream | (eos_pending_r & ~eos_clear_s);

    for (int i = 0; i < NUM_LANES; i++) begin
      others_active_s = others_active_s |
                        ((lane_state_s[i] != LANE_IDLE) && (LANE_W'(i) != out_lane_s));
    end
    out_last_s = out_valid_s & eos_pending_s & ~others_active_s;
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_state_r[i] <= LANE_IDLE;
        lane_tag_r[i]   <= 32'd0;
        lane_iter_r[i]  <= 16'd0;
      end
      base_addr_r       <= 32'd0;
      real_idx_r        <= '0;
      imag_idx_r        <= '0;
      load_ptr_r        <= '0;
      last_grant_r      <= '0;
      out_lane_r        <= '0;
      eos_pending_r     <= 1'b0;
      out_valid_r       <= 1'b0;
      out_last_r        <= 1'b0;
      out_addr_r        <= 32'd0;
      out_data_r        <= 16'd0;
      wr_real_en_r      <= '0;
      wr_imag_en_r      <= '0;
      start_r           <= '0;
      wr_index_r        <= '0;
      num_limbs_r       <= '0;
      limb_data_r       <= '0;
      wr_num_limbs_en_r <= 1'b0;
      wr_iter_lim_en_r  <= 1'b0;
      iter_lim_r        <= 16'd0;
    end else begin
      lane_state_r      <= lane_state_s;
      lane_tag_r        <= lane_tag_s;
      lane_iter_r       <= lane_iter_s;
      base_addr_r       <= base_addr_s;
      real_idx_r        <= real_idx_s;
      imag_idx_r        <= imag_idx_s;
      load_ptr_r        <= load_ptr_s;
      last_grant_r      <= last_grant_s;
      out_lane_r        <= out_lane_s;
      eos_pending_r     <= eos_pending_s;
      out_valid_r       <= out_valid_s;
      out_last_r        <= out_last_s;
      out_addr_r        <= out_addr_s;
      out_data_r        <= out_data_s;
      wr_real_en_r      <= wr_real_en_s;
      wr_imag_en_r      <= wr_imag_en_s;
      start_r           <= start_s;
      wr_index_r        <= wr_index_s;
      num_limbs_r       <= num_limbs_s;
      limb_data_r       <= limb_data_s;
      wr_num_limbs_en_r <= wr_num_limbs_en_s;
      wr_iter_lim_en_r  <= wr_iter_lim_en_s;
      iter_lim_r        <= iter_lim_s;
    end
  end

  assign out_valid         = out_valid_r;
  assign out_last          = out_last_r;
  assign out_addr          = out_addr_r;
  assign out_data          = out_data_r;
  assign s_wr_real_en      = wr_real_en_r;
  assign s_wr_imag_en      = wr_imag_en_r;
  assign s_wr_index        = wr_index_r;
  assign s_limb_data       = limb_data_r;
  assign s_wr_num_limbs_en = wr_num_limbs_en_r;
  assign s_num_limbs       = num_limbs_r;
  assign s_wr_iter_lim_en  = wr_iter_lim_en_r;
  assign s_iter_lim        = iter_lim_r;
  assign s_start           = start_r;

endmodule

// File: tb/tb_tile_dispatcher.sv
// Bench for tile_dispatcher: directed scenarios plus a randomized run scored
// against a transaction-level model of lanes, tags and returned results.
module tb_tile_dispatcher;
  localparam int NL = 4;
  localparam int IB = 6;
  localparam int SB = 27;

  logic          clock, reset;
  logic [31:0]   in_data;
  logic          in_valid, in_ready, in_end_of_stream;
  logic [31:0]   out_addr;
  logic [15:0]   out_data;
  logic          out_last, out_valid, out_ready;
  logic [NL-1:0] s_wr_real_en, s_wr_imag_en, s_start, s_done;
  logic [IB-1:0] s_wr_index, s_num_limbs;
  logic [SB-1:0] s_limb_data;
  logic          s_wr_num_limbs_en, s_wr_iter_lim_en;
  logic [15:0]   s_iter_lim;
  logic [16*NL-1:0] s_iterations;

  int checks = 0;
  int errors = 0;

  bit          m_occ   [NL];
  bit          m_dsent [NL];
  logic [31:0] m_tag   [NL];
  logic [15:0] m_iter  [NL];
  int          m_lp, m_ridx, m_iidx;
  logic [31:0] m_base;

  tile_dispatcher #(.NUM_LANES(NL), .LIMB_INDEX_BITS(IB), .LIMB_SIZE_BITS(SB)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_end_of_stream(in_end_of_stream),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .s_wr_real_en(s_wr_real_en), .s_wr_imag_en(s_wr_imag_en),
    .s_wr_index(s_wr_index), .s_limb_data(s_limb_data),
    .s_wr_num_limbs_en(s_wr_num_limbs_en), .s_num_limbs(s_num_limbs),
    .s_wr_iter_lim_en(s_wr_iter_lim_en), .s_iter_lim(s_iter_lim),
    .s_start(s_start), .s_done(s_done), .s_iterations(s_iterations)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_end_of_stream = 1'b0;
    out_ready = 1'b0; s_done = '0; s_iterations = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic send(input logic [2:0] t, input logic [28:0] p, input int budget, output bit ok);
    ok = 1'b0;
    in_data = {t, p};
    in_valid = 1'b1;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    if (ok) @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic take(output logic [31:0] a, output logic [15:0] d, output logic l, output bit ok);
    ok = 1'b0; a = '0; d = '0; l = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (out_valid) begin a = out_addr; d = out_data; l = out_last; ok = 1'b1; break; end
      @(negedge clock);
    end
    if (ok) @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic pulse_done(input logic [NL-1:0] mask, input logic [16*NL-1:0] iters);
    s_done = mask;
    s_iterations = iters;
    @(negedge clock);
    s_done = '0;
  endtask

  task automatic pulse_eos();
    in_end_of_stream = 1'b1;
    @(negedge clock);
    in_end_of_stream = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_end_of_stream = 1'b0;
    out_ready = 1'b0; s_done = '0; s_iterations = '0;
    repeat (2) @(negedge clock);
    checks++;
    if ({out_valid, out_last, s_start, s_wr_real_en, s_wr_imag_en, s_wr_num_limbs_en,
         s_wr_iter_lim_en, s_iter_lim, s_num_limbs, s_wr_index, s_limb_data} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs expected all zero");
    end
    reset = 1'b0;
    in_data = {3'd4, 29'd0};
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    bit ok; logic [31:0] a; logic [15:0] d; logic l;
    do_reset();
    send(3'd0, 29'h100, 4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL base_accept: got 0 expected 1"); end
    send(3'd1, (29'd2 << 16) | 29'd50, 4, ok);
    checks++;
    if ({ok, s_wr_num_limbs_en, s_wr_iter_lim_en, s_num_limbs, s_iter_lim} !== {1'b1, 1'b1, 1'b1, 6'd2, 16'd50}) begin
      errors++; $display("FAIL config: got en=%b%b limbs=%0d iter=%0d expected 11 2 50",
                         s_wr_num_limbs_en, s_wr_iter_lim_en, s_num_limbs, s_iter_lim);
    end
    @(negedge clock);
    checks++;
    if ({s_wr_num_limbs_en, s_wr_iter_lim_en} !== 2'b00) begin
      errors++; $display("FAIL config_pulse: got %b%b expected 00", s_wr_num_limbs_en, s_wr_iter_lim_en);
    end
    send(3'd2, 29'h123, 4, ok);
    checks++;
    if ({s_wr_real_en, s_wr_index, s_limb_data} !== {4'b0001, 6'd0, 27'h123}) begin
      errors++; $display("FAIL real_limb: got en=%b idx=%0d data=%h expected 0001 0 123", s_wr_real_en, s_wr_index, s_limb_data);
    end
    send(3'd3, 29'h456, 4, ok);
    checks++;
    if ({s_wr_imag_en, s_wr_real_en, s_wr_index, s_limb_data} !== {4'b0001, 4'b0000, 6'd0, 27'h456}) begin
      errors++; $display("FAIL imag_limb: got en=%b idx=%0d data=%h expected 0001 0 456", s_wr_imag_en, s_wr_index, s_limb_data);
    end
    send(3'd4, 29'd0, 4, ok);
    checks++; if (s_start !== 4'b0001) begin errors++; $display("FAIL start_lane0: got %b expected 0001", s_start); end
    @(negedge clock);
    checks++; if (s_start !== 4'b0000) begin errors++; $display("FAIL start_pulse: got %b expected 0000", s_start); end
    pulse_done(4'b0001, 64'd17);
    take(a, d, l, ok);
    checks++;
    if ({ok, a, d, l} !== {1'b1, 32'h100, 16'd17, 1'b0}) begin
      errors++; $display("FAIL basic_result: got ok=%b addr=%h data=%0d last=%b expected 1 100 17 0", ok, a, d, l);
    end
  endtask

  task automatic test_stall();
    bit ok; logic [31:0] a; logic [15:0] d; logic l;
    do_reset();
    send(3'd0, 29'h40, 4, ok);
    for (int i = 0; i < NL; i++) begin
      send(3'd4, 29'd0, 4, ok);
      checks++;
      if (s_start !== 4'(1 << i)) begin errors++; $display("FAIL stall_start%0d: got %b expected %b", i, s_start, 4'(1 << i)); end
    end
    send(3'd4, 29'd0, 4, ok);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL fifth_stall: got accepted expected in_ready 0"); end
    pulse_done(4'b0001, 64'd5);
    take(a, d, l, ok);
    checks++;
    if ({ok, a, d} !== {1'b1, 32'h40, 16'd5}) begin errors++; $display("FAIL stall_result0: got addr=%h data=%0d expected 40 5", a, d); end
    send(3'd4, 29'd0, 4, ok);
    checks++;
    if ({ok, s_start} !== {1'b1, 4'b0001}) begin errors++; $display("FAIL fifth_start: got ok=%b start=%b expected 1 0001", ok, s_start); end
    pulse_done(4'b0001, 64'd9);
    take(a, d, l, ok);
    checks++;
    if ({ok, a, d} !== {1'b1, 32'h44, 16'd9}) begin errors++; $display("FAIL fifth_addr: got addr=%h data=%0d expected 44 9", a, d); end
  endtask

  task automatic test_arbiter();
    bit ok; logic [31:0] a; logic [15:0] d; logic l;
    do_reset();
    for (int i = 0; i < NL; i++) send(3'd4, 29'd0, 4, ok);
    pulse_done(4'b1010, {16'd33, 16'd0, 16'd11, 16'd0});
    for (int c = 0; c < 10; c++) begin
      if (out_valid) break;
      @(negedge clock);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({out_valid, out_addr, out_data} !== {1'b1, 32'd1, 16'd11}) begin
        errors++; $display("FAIL arb_hold%0d: got v=%b addr=%h data=%0d expected 1 1 11", c, out_valid, out_addr, out_data);
      end
      if (c < 3) @(negedge clock);
    end
    take(a, d, l, ok);
    checks++; if ({ok, a, d} !== {1'b1, 32'd1, 16'd11}) begin errors++; $display("FAIL arb_first: got addr=%h data=%0d expected 1 11", a, d); end
    take(a, d, l, ok);
    checks++; if ({ok, a, d} !== {1'b1, 32'd3, 16'd33}) begin errors++; $display("FAIL arb_second: got addr=%h data=%0d expected 3 33", a, d); end
  endtask

  task automatic test_index();
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(3'd2, 29'(i + 7), 4, ok);
      checks++;
      if ({s_wr_real_en, s_wr_index} !== {4'b0001, 6'(i)}) begin
        errors++; $display("FAIL index_real%0d: got en=%b idx=%0d expected 0001 %0d", i, s_wr_real_en, s_wr_index, i);
      end
    end
    send(3'd3, 29'd1, 4, ok);
    checks++; if ({s_wr_imag_en, s_wr_index} !== {4'b0001, 6'd0}) begin errors++; $display("FAIL index_imag: got en=%b idx=%0d expected 0001 0", s_wr_imag_en, s_wr_index); end
    send(3'd4, 29'd0, 4, ok);
    send(3'd2, 29'd3, 4, ok);
    checks++; if ({s_wr_real_en, s_wr_index} !== {4'b0010, 6'd0}) begin errors++; $display("FAIL index_next_lane: got en=%b idx=%0d expected 0010 0", s_wr_real_en, s_wr_index); end
  endtask

  task automatic test_eos();
    bit ok; bit seen; logic [31:0] a; logic [15:0] d; logic l;
    do_reset();
    pulse_eos();
    seen = 1'b0;
    repeat (4) begin @(negedge clock); seen = seen | out_valid; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL eos_idle: got out_valid expected none"); end
    send(3'd4, 29'd0, 4, ok);
    pulse_done(4'b0001, 64'd3);
    take(a, d, l, ok);
    checks++; if ({ok, a, l} !== {1'b1, 32'd0, 1'b0}) begin errors++; $display("FAIL eos_idle_cleared: got addr=%h last=%b expected 0 0", a, l); end
    send(3'd4, 29'd0, 4, ok);
    send(3'd4, 29'd0, 4, ok);
    pulse_eos();
    pulse_done(4'b0010, 64'd7 << 16);
    take(a, d, l, ok);
    checks++; if ({ok, a, d, l} !== {1'b1, 32'd1, 16'd7, 1'b0}) begin errors++; $display("FAIL eos_first: got addr=%h data=%0d last=%b expected 1 7 0", a, d, l); end
    pulse_done(4'b0100, 64'd8 << 32);
    take(a, d, l, ok);
    checks++; if ({ok, a, d, l} !== {1'b1, 32'd2, 16'd8, 1'b1}) begin errors++; $display("FAIL eos_last: got addr=%h data=%0d last=%b expected 2 8 1", a, d, l); end
    send(3'd4, 29'd0, 4, ok);
    pulse_done(4'b1000, 64'd4 << 48);
    take(a, d, l, ok);
    checks++; if ({ok, a, l} !== {1'b1, 32'd3, 1'b0}) begin errors++; $display("FAIL eos_cleared: got addr=%h last=%b expected 3 0", a, l); end
  endtask

  task automatic test_reset_mid();
    bit ok; bit seen;
    do_reset();
    send(3'd4, 29'd0, 4, ok);
    send(3'd4, 29'd0, 4, ok);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    pulse_done(4'b0011, {$urandom, $urandom});
    seen = 1'b0;
    repeat (5) begin @(negedge clock); seen = seen | out_valid; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_valid: got out_valid expected none"); end
    in_data = {3'd4, 29'd0};
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b expected 1", in_ready); end
    @(negedge clock);
    send(3'd4, 29'd0, 4, ok);
    checks++; if (s_start !== 4'b0001) begin errors++; $display("FAIL reset_mid_start: got %b expected 0001", s_start); end
  endtask

  function automatic bit any_done();
    bit r = 1'b0;
    for (int i = 0; i < NL; i++) r = r | (m_occ[i] & m_dsent[i]);
    return r;
  endfunction

  function automatic bit any_occ();
    bit r = 1'b0;
    for (int i = 0; i < NL; i++) r = r | m_occ[i];
    return r;
  endfunction

  task automatic pulse_done_m(input logic [NL-1:0] mask, input logic [16*NL-1:0] iters);
    for (int i = 0; i < NL; i++) begin
      if (mask[i] && m_occ[i] && !m_dsent[i]) begin
        m_dsent[i] = 1'b1;
        m_iter[i]  = iters[16*i +: 16];
      end
    end
    pulse_done(mask, iters);
  endtask

  task automatic drain_one();
    logic [31:0] a; logic [15:0] d; logic l; bit ok; int hit;
    take(a, d, l, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rand_drain: got no out_valid expected a result beat");
    end else begin
      hit = -1;
      for (int i = 0; i < NL; i++) if (m_occ[i] && m_dsent[i] && m_tag[i] == a) hit = i;
      if (hit < 0) begin
        errors++; $display("FAIL rand_addr: got %h expected a completed lane tag", a);
      end else begin
        checks++;
        if ({d, l} !== {m_iter[hit], 1'b0}) begin
          errors++; $display("FAIL rand_data: got data=%0d last=%b expected %0d 0", d, l, m_iter[hit]);
        end
        m_occ[hit] = 1'b0;
        m_dsent[hit] = 1'b0;
      end
    end
  endtask

  task automatic ensure_free(input int lane);
    logic [NL-1:0] m;
    if (m_occ[lane] && !m_dsent[lane]) begin
      m = '0; m[lane] = 1'b1;
      pulse_done_m(m, {$urandom, $urandom});
    end
    for (int g = 0; g < 10 && m_occ[lane]; g++) drain_one();
  endtask

  task automatic test_random();
    logic [28:0] p; bit ok; int n; logic [NL-1:0] oh; logic [NL-1:0] m; logic [2:0] t;
    do_reset();
    for (int i = 0; i < NL; i++) begin m_occ[i] = 1'b0; m_dsent[i] = 1'b0; end
    m_lp = 0; m_ridx = 0; m_iidx = 0;
    p = 29'($urandom);
    send(3'd0, p, 4, ok);
    m_base = {3'b000, p};
    p = 29'($urandom);
    send(3'd1, p, 4, ok);
    checks++;
    if ({s_iter_lim, s_num_limbs} !== {p[15:0], p[21:16]}) begin
      errors++; $display("FAIL rand_config: got %0d %0d expected %0d %0d", s_iter_lim, s_num_limbs, p[15:0], p[21:16]);
    end
    for (int px = 0; px < 24; px++) begin
      ensure_free(m_lp);
      oh = '0; oh[m_lp] = 1'b1;
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        p = 29'($urandom);
        send(3'd2, p, 8, ok);
        checks++;
        if ({ok, s_wr_real_en, s_wr_imag_en, s_wr_index, s_limb_data} !== {1'b1, oh, 4'b0000, 6'(m_ridx), p[SB-1:0]}) begin
          errors++; $display("FAIL rand_real: got en=%b idx=%0d expected %b %0d", s_wr_real_en, s_wr_index, oh, m_ridx);
        end
        m_ridx = (m_ridx + 1) % 64;
      end
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        p = 29'($urandom);
        send(3'd3, p, 8, ok);
        checks++;
        if ({ok, s_wr_imag_en, s_wr_real_en, s_wr_index, s_limb_data} !== {1'b1, oh, 4'b0000, 6'(m_iidx), p[SB-1:0]}) begin
          errors++; $display("FAIL rand_imag: got en=%b idx=%0d expected %b %0d", s_wr_imag_en, s_wr_index, oh, m_iidx);
        end
        m_iidx = (m_iidx + 1) % 64;
      end
      if ($urandom_range(0, 3) == 0) begin
        t = 3'($urandom_range(5, 7));
        send(t, 29'($urandom), 4, ok);
        checks++;
        if ({ok, s_wr_real_en, s_wr_imag_en, s_start} !== {1'b1, 12'd0}) begin
          errors++; $display("FAIL rand_ignored: got ok=%b strobes=%b%b%b expected 1 and zero", ok, s_wr_real_en, s_wr_imag_en, s_start);
        end
      end
      send(3'd4, 29'($urandom), 8, ok);
      checks++;
      if ({ok, s_start} !== {1'b1, oh}) begin
        errors++; $display("FAIL rand_start: got ok=%b start=%b expected 1 %b", ok, s_start, oh);
      end
      m_occ[m_lp] = 1'b1; m_dsent[m_lp] = 1'b0; m_tag[m_lp] = m_base;
      m_base = m_base + 32'd1; m_ridx = 0; m_iidx = 0; m_lp = (m_lp + 1) % NL;
      if ($urandom_range(0, 1) == 1) begin
        m = NL'($urandom);
        pulse_done_m(m, {$urandom, $urandom});
      end
      if ($urandom_range(0, 1) == 1 && any_done()) drain_one();
    end
    for (int i = 0; i < NL; i++) m[i] = m_occ[i] & ~m_dsent[i];
    pulse_done_m(m, {$urandom, $urandom});
    for (int g = 0; g < 10 && any_occ(); g++) drain_one();
    repeat (2) @(negedge clock);
    checks++;
    if ({any_occ(), out_valid} !== 2'b00) begin
      errors++; $display("FAIL rand_final: got outstanding=%b out_valid=%b expected 0 0", any_occ(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_arbiter();
    test_index();
    test_eos();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
